clockdemux_piso: RTL and testbench
==================================

CLOCKDEMUX_PISO -- requirements
Module: clockdemux_piso

Interface
REQ-001 Parameter: DIV, default 4, clk cycles per serial bit; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: paralelo_in  input  8  parallel byte to serialize.
REQ-005 Port: load_valid  input  1  paralelo_in is valid.
REQ-006 Port: load_ready  output  1  holding buffer is empty; a byte is accepted when load_valid and load_ready are both high at a clk edge.
REQ-007 Port: saida  output  1  demultiplexed bit clock, period DIV clk cycles, 50% duty.
REQ-008 Port: linha  output  1  serial data line.
REQ-009 Port: busy  output  1  shifter is holding a byte that is still being transmitted.

Function
REQ-010 Divider: a counter SHALL run 0..DIV-1 and wrap to 0; bit_tick is an internal one-cycle pulse when counter == DIV-1.
REQ-011 saida SHALL be 1 when counter >= DIV/2, else 0; its rising edge is therefore mid-bit, so a sink sampling linha on that edge sees stable data.
REQ-012 Holding buffer: an accepted byte SHALL be stored and load_ready SHALL drop in the next cycle.
REQ-013 On bit_tick with the shifter idle or on its last bit (bit index 7) and the holding buffer full, the byte SHALL move to the shifter, bit index SHALL reset to 0, and the holding buffer SHALL become empty.
REQ-014 On any other bit_tick with the shifter busy, the shifter SHALL shift right one place and bit index SHALL increment.
REQ-015 linha SHALL be shifter bit 0 while busy, giving LSB-first order with each bit held exactly DIV clk cycles; it SHALL be 1 while idle.
REQ-016 After bit 7 with the holding buffer empty, the shifter SHALL go idle and busy SHALL drop at that bit_tick.
REQ-017 A load accepted in the same cycle the holding buffer transfers to the shifter SHALL be stored into the freed buffer; no byte is lost or duplicated.
REQ-018 load_valid while load_ready is low SHALL be ignored.
REQ-019 Back-to-back bytes SHALL be serialized with no idle bit between frames.

Reset
REQ-020 While rst_n is low: counter = 0, saida = 0, linha = 1, busy = 0, holding buffer empty, load_ready = 1, bit index = 0, frame_sync = 0 (when built).
REQ-021 Reset asserted mid-frame SHALL discard both the shifter and holding contents.
REQ-022 After rst_n rises, the first bit_tick SHALL occur DIV clk edges later.

Configuration
REQ-023 Macro CLOCKDEMUX_PISO_FRAME_SYNC_EN, when defined, SHALL add output frame_sync (1 bit). It is high for exactly the DIV clk cycles in which bit 0 of a frame is on linha, and 0 otherwise.
REQ-024 Without CLOCKDEMUX_PISO_FRAME_SYNC_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 DIV=4, reset released: saida is 0 for 2 clk cycles, then 1 for 2 clk cycles, repeating. linha = 1, load_ready = 1, busy = 0.
REQ-026 Load 0xA5 while idle: sampled on saida rising edges, linha is 1,0,1,0,0,1,0,1 and each bit lasts 4 clk cycles. After that, linha returns to 1 and busy falls.
REQ-027 Load 0x3C, then 0xFF held valid: the stream is 0,0,1,1,1,1,0,0,1,1,1,1,1,1,1,1 with no gap. load_ready reasserts when 0xFF leaves the holding buffer.
REQ-028 Pulse rst_n low during bit 3 of 0x0F: linha = 1, busy = 0 and load_ready = 1 immediately, and no further data bits appear.
REQ-029 load_valid with 0x55 while the holding buffer is full: the byte is not accepted and the output stream is unchanged.
REQ-030 With CLOCKDEMUX_PISO_FRAME_SYNC_EN and DIV=4, two back-to-back frames: frame_sync is high for 4 clk cycles at the start of each frame, 32 clk cycles apart.

Source files
------------

// File: rtl/clockdemux_piso.sv
// rtl/clockdemux_piso.sv - byte serializer with divided bit clock and one-byte holding buffer
// Optional CLOCKDEMUX_PISO_FRAME_SYNC_EN adds frame_sync, high during bit 0 of each frame.
module clockdemux_piso #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] paralelo_in,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       saida,
  output logic       linha,
`ifdef CLOCKDEMUX_PISO_FRAME_SYNC_EN
  output logic       busy,
  output logic       frame_sync
`else
  output logic       busy
`endif
);

  localparam int CW = $clog2(DIV);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    hold_q, hold_d;
  logic          full_q, full_d;
  logic          bit_tick;
  logic          accept;
  logic          take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    full_d   = full_q;
    bit_tick = (cnt_q == CW'(DIV - 1));
    cnt_d    = bit_tick ? '0 : cnt_q + 1'b1;
    accept   = load_valid && !full_q;
    // The holding byte only enters at a frame boundary, so frames abut with no idle bit.
    take     = bit_tick && full_q && (state_q == IDLE || idx_q == 3'd7);

    if (take) begin
      shift_d = hold_q;
      idx_d   = 3'd0;
      state_d = SEND;
      full_d  = 1'b0;
    end else if (bit_tick && state_q == SEND) begin
      if (idx_q == 3'd7) begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end else begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 3'd1;
      end
    end

    if (accept) begin
      hold_d = paralelo_in;
      full_d = 1'b1;
    end
  end

  assign load_ready = !full_q;
  assign busy       = (state_q == SEND);
  assign linha      = busy ? shift_q[0] : 1'b1;
  // Upper half of the bit period, so the rising edge lands mid-bit.
  assign saida      = (cnt_q >= CW'(DIV / 2));

`ifdef CLOCKDEMUX_PISO_FRAME_SYNC_EN
  assign frame_sync = busy && (idx_q == 3'd0);
`endif

endmodule

// File: tb/tb_clockdemux_piso.sv
// tb/tb_clockdemux_piso.sv - randomized self-checking bench for clockdemux_piso
// Frames are modelled as scheduled time windows rather than a shifter.
module tb_clockdemux_piso;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] paralelo_in = 8'h00;
  logic       load_valid = 1'b0;
  logic       load_ready, saida, linha, busy;
`ifdef CLOCKDEMUX_PISO_FRAME_SYNC_EN
  logic       frame_sync;
`endif

  clockdemux_piso #(.DIV(DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .paralelo_in(paralelo_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .saida(saida),
    .linha(linha),
`ifdef CLOCKDEMUX_PISO_FRAME_SYNC_EN
    .busy(busy),
    .frame_sync(frame_sync)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // n = rising edges since reset release; each frame: accept edge, start edge, data.
  int         n = 0;
  int         fa[$];
  int         fs[$];
  logic [7:0] fd[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t n=%0d actual=%0h expected=%0h", nm, $time, n, act, exp);
    end
  endtask

  function automatic bit m_ready(input int nn);
    foreach (fa[i]) if (fa[i] <= nn && nn < fs[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int frame_at(input int nn);
    foreach (fs[i]) if (fs[i] <= nn && nn < fs[i] + 8 * DIV) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int a, s;
    if (!rst_n) begin
      n = 0;
      fa.delete();
      fs.delete();
      fd.delete();
    end else begin
      if (load_valid && m_ready(n)) begin
        a = n + 1;
        s = (a / DIV + 1) * DIV;
        if (fs.size() > 0 && fs[fs.size()-1] + 8 * DIV > s) s = fs[fs.size()-1] + 8 * DIV;
        fa.push_back(a);
        fs.push_back(s);
        fd.push_back(paralelo_in);
      end
      n = n + 1;
    end
  end

  always @(negedge clk) begin : compare
    int  k;
    logic el;
    if (rst_n) begin
      k  = frame_at(n);
      el = (k < 0) ? 1'b1 : fd[k][(n - fs[k]) / DIV];
      chk("saida", saida, ((n % DIV) >= DIV / 2));
      chk("linha", linha, el);
      chk("busy", busy, (k >= 0));
      chk("load_ready", load_ready, m_ready(n));
`ifdef CLOCKDEMUX_PISO_FRAME_SYNC_EN
      chk("frame_sync", frame_sync, (k >= 0 && (n - fs[k]) < DIV));
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    while (!m_ready(n) && g < 300) begin step(); g++; end
    chk("send_timeout", (g < 300), 1);
    paralelo_in = b;
    load_valid  = 1'b1;
    step();
    load_valid  = 1'b0;
  endtask

  task automatic wait_busy();
    int g = 0;
    while (busy !== 1'b1 && g < 300) begin step(); g++; end
    chk("busy_timeout", (g < 300), 1);
  endtask

  task automatic capture(input int nb, output logic [15:0] v);
    logic prev;
    int cnt = 0;
    int g = 0;
    v = '0;
    prev = saida;
    while (cnt < nb && g < 400) begin
      step();
      if (saida && !prev) begin v[cnt] = linha; cnt++; end
      prev = saida;
      g++;
    end
    chk("capture_timeout", (g < 400), 1);
  endtask

  initial begin
    logic [15:0] v;
    logic [7:0]  pat;
    int          g;

    step(); step();
    chk("rst_linha", linha, 1);
    chk("rst_busy", busy, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_saida", saida, 0);
    rst_n = 1'b1;

    pat = 8'hCC;
    for (int i = 0; i < 8; i++) begin
      chk("saida_pattern", saida, pat[i]);
      chk("idle_linha", linha, 1);
      step();
    end

    send_byte(8'hA5);
    wait_busy();
    capture(8, v);
    chk("frame_a5", v[7:0], 8'hA5);
    for (int i = 0; i < 20; i++) step();
    chk("a5_done_busy", busy, 0);

    send_byte(8'h3C);
    send_byte(8'hFF);
    wait_busy();
    capture(16, v);
    chk("stream_3c_ff", v, 16'hFF3C);
    for (int i = 0; i < 20; i++) step();

    send_byte(8'h11);
    send_byte(8'h22);
    paralelo_in = 8'h55;
    load_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_not_ready", load_ready, 0);
      step();
    end
    load_valid = 1'b0;
    for (int i = 0; i < 80; i++) step();

    send_byte(8'h0F);
    wait_busy();
    g = 0;
    while (n < fs[fs.size()-1] + 3 * DIV + 1 && g < 100) begin step(); g++; end
    chk("bit3_timeout", (g < 100), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_linha", linha, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_load_ready", load_ready, 1);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) step();

    for (int i = 0; i < 1500; i++) begin
      load_valid  = ($urandom_range(0, 2) == 0);
      paralelo_in = 8'($urandom);
      step();
    end
    load_valid = 1'b0;
    for (int i = 0; i < 100; i++) step();

`ifdef CLOCKDEMUX_PISO_FRAME_SYNC_EN
    begin
      int r0, r1, seen;
      logic prev;
      send_byte(8'h96);
      send_byte(8'h69);
      seen = 0; r0 = 0; r1 = 0; g = 0;
      prev = frame_sync;
      while (seen < 2 && g < 200) begin
        step();
        if (frame_sync && !prev) begin
          if (seen == 0) r0 = n; else r1 = n;
          seen++;
        end
        prev = frame_sync;
        g++;
      end
      chk("fsync_timeout", (g < 200), 1);
      chk("fsync_spacing", r1 - r0, 8 * DIV);
      for (int i = 0; i < 60; i++) step();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
